alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU. Successor to the 16-bit combinational 16-function logic/arithmetic ALU.
- Adds configurable width, a real carry chain (carry_in consumed, carry_out generated), zero/compare flags, a passthrough tag, and valid/ready handshakes on both sides.
- Sits between the operand-issue logic and the writeback/result buffer of the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits (>= 2).
- TAG_W, 4, width of the transaction tag carried alongside each operation (>= 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- select  in  4  function select.
- mode  in  1  1 = logic, 0 = arithmetic.
- carry_in  in  1  active-high carry into the arithmetic sum.
- in_tag  in  TAG_W  transaction tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- alu_out  out  WIDTH  result.
- carry_out  out  1  carry out of bit WIDTH-1.
- zero  out  1  alu_out == 0.
- compare  out  1  in_a == in_b for this transaction.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset
  - When rst_n == 0 at a clock edge, both pipeline valid bits clear and all output registers clear (alu_out, carry_out, zero, compare, out_tag all 0).
  - out_valid = 0 during and after reset. in_ready = 1 once the pipeline is empty.
  - Reset mid-operation discards any in-flight transaction; no result is ever emitted for it.
- Handshake
  - Input transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - Stall = out_valid && !out_ready. When stalled, both stages hold and in_ready = 0. Otherwise in_ready = 1.
  - While out_valid && !out_ready, all outputs stay stable.
- Latency and throughput
  - Exactly 2 cycles from input transfer to out_valid with no backpressure.
  - One operation per cycle sustained. Order is preserved. No transaction is dropped or duplicated.
- Stage 1: registers A, B, carry_in, mode, select and tag. Computes compare.
- Stage 2: computes the result, carry and zero, then registers them.
- Logic mode (mode = 1), select 0..15:
  - Functions: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A.
  - carry_out = 0. carry_in is ignored.
- Arithmetic mode (mode = 0)
  - Result = X + Y + carry_in, computed at WIDTH+1 bits. alu_out = low WIDTH bits. carry_out = bit WIDTH.
  - (X, Y) per select:
    - 0: (A, 0)
    - 1: (A|B, 0)
    - 2: (A|~B, 0)
    - 3: (0, all-ones)
    - 4: (A, A&~B)
    - 5: (A|B, A&~B)
    - 6: (A, ~B)
    - 7: (A&~B, all-ones)
    - 8: (A, A&B)
    - 9: (A, B)
    - 10: (A|~B, A&B)
    - 11: (A&B, all-ones)
    - 12: (A, A)
    - 13: (A|B, A)
    - 14: (A|~B, A)
    - 15: (A, all-ones)
  - Wrap-around is modulo 2^WIDTH. There is no saturation.
- Flags
  - zero reflects the final alu_out in both modes.
  - compare is independent of mode and select.
- Inputs while in_ready = 0 are ignored, whatever the value of in_valid.

Test Plan:
- Reset: assert rst_n = 0 for 2 cycles with in_valid = 1 -> out_valid = 0; alu_out, carry_out, zero, compare, out_tag all 0; in_ready = 1 after release.
- WIDTH = 16, mode 0, select 9, A = 0xFFFF, B = 0x0001, cin = 0, tag = 3 -> 2 cycles later: alu_out = 0x0000, carry_out = 1, zero = 1, compare = 0, out_tag = 3.
- WIDTH = 16, mode 0, select 6, A = 5, B = 3, cin = 1 -> alu_out = 0x0002, carry_out = 1; same with cin = 0 -> 0x0001, carry_out = 1.
- WIDTH = 16, mode 1, select 6, A = 0xAAAA, B = 0x5555, cin = 1 -> alu_out = 0xFFFF, carry_out = 0, zero = 0; then select 15 with A = B = 0x1234 -> alu_out = 0x1234, compare = 1.
- Backpressure: 4 back-to-back inputs with tags 0..3, out_ready = 0 for cycles 2..5 -> in_ready falls and outputs hold tag 0 stable; after release, tags 0,1,2,3 emerge in order with no loss or duplication.
- WIDTH = 8: mode 0, select 12, A = 0x80, cin = 1 -> alu_out = 0x01, carry_out = 1. Also pull rst_n low 1 cycle after an input -> that result never appears (out_valid stays 0).

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined logic/arithmetic ALU with carry chain, flags,
// a passthrough tag and valid/ready handshakes on both sides.
// Stage 1 registers the operation and the operand-equality flag; stage 2
// computes result, carry and zero and registers them as the outputs.
// A stalled output (out_valid && !out_ready) freezes both stages.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    input  logic             mode,
    input  logic             carry_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             zero,
    output logic             compare,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] NONE = '0;

    logic             stall;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_sel;
    logic             s1_mode;
    logic             s1_cin;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_cmp;

    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    // Backpressure only comes from a result that has not been taken yet.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1: capture the operation and the operand-equality flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            s1_mode  <= 1'b0;
            s1_cin   <= 1'b0;
            s1_tag   <= '0;
            s1_cmp   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_sel  <= select;
                s1_mode <= mode;
                s1_cin  <= carry_in;
                s1_tag  <= in_tag;
                s1_cmp  <= (in_a == in_b);
            end
        end
    end

    // Logic-mode function table.
    always_comb begin
        logic_res = NONE;
        case (s1_sel)
            4'd0:  logic_res = ~s1_a;
            4'd1:  logic_res = ~(s1_a | s1_b);
            4'd2:  logic_res = ~s1_a & s1_b;
            4'd3:  logic_res = NONE;
            4'd4:  logic_res = ~(s1_a & s1_b);
            4'd5:  logic_res = ~s1_b;
            4'd6:  logic_res = s1_a ^ s1_b;
            4'd7:  logic_res = s1_a & ~s1_b;
            4'd8:  logic_res = ~s1_a | s1_b;
            4'd9:  logic_res = ~(s1_a ^ s1_b);
            4'd10: logic_res = s1_b;
            4'd11: logic_res = s1_a & s1_b;
            4'd12: logic_res = ONES;
            4'd13: logic_res = s1_a | ~s1_b;
            4'd14: logic_res = s1_a | s1_b;
            default: logic_res = s1_a;
        endcase
    end

    // Arithmetic-mode operand selection feeding one WIDTH+1 bit adder.
    always_comb begin
        op_x = s1_a;
        op_y = NONE;
        case (s1_sel)
            4'd0:  begin op_x = s1_a;          op_y = NONE;          end
            4'd1:  begin op_x = s1_a | s1_b;   op_y = NONE;          end
            4'd2:  begin op_x = s1_a | ~s1_b;  op_y = NONE;          end
            4'd3:  begin op_x = NONE;          op_y = ONES;          end
            4'd4:  begin op_x = s1_a;          op_y = s1_a & ~s1_b;  end
            4'd5:  begin op_x = s1_a | s1_b;   op_y = s1_a & ~s1_b;  end
            4'd6:  begin op_x = s1_a;          op_y = ~s1_b;         end
            4'd7:  begin op_x = s1_a & ~s1_b;  op_y = ONES;          end
            4'd8:  begin op_x = s1_a;          op_y = s1_a & s1_b;   end
            4'd9:  begin op_x = s1_a;          op_y = s1_b;          end
            4'd10: begin op_x = s1_a | ~s1_b;  op_y = s1_a & s1_b;   end
            4'd11: begin op_x = s1_a & s1_b;   op_y = ONES;          end
            4'd12: begin op_x = s1_a;          op_y = s1_a;          end
            4'd13: begin op_x = s1_a | s1_b;   op_y = s1_a;          end
            4'd14: begin op_x = s1_a | ~s1_b;  op_y = s1_a;          end
            default: begin op_x = s1_a;        op_y = ONES;          end
        endcase
    end

    // Adder and mode mux; carry is forced low in logic mode.
    always_comb begin
        sum       = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, s1_cin};
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        if (s1_mode) begin
            res       = logic_res;
            res_carry = 1'b0;
        end
    end

    // Stage 2: register result and flags; bubbles leave the data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            compare   <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                alu_out   <= res;
                carry_out <= res_carry;
                zero      <= (res == NONE);
                compare   <= s1_cmp;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases, backpressure, randomized
// traffic against a reference model, and an 8-bit instance for width/reset cases.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  select;
    logic        mode;
    logic        carry_in;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic        carry_out;
    logic        zero;
    logic        compare;
    logic [3:0]  out_tag;

    logic        x_rst_n;
    logic        x_in_valid;
    logic        x_in_ready;
    logic [7:0]  x_in_a;
    logic [7:0]  x_in_b;
    logic [3:0]  x_select;
    logic        x_mode;
    logic        x_carry_in;
    logic [3:0]  x_in_tag;
    logic        x_out_valid;
    logic        x_out_ready;
    logic [7:0]  x_alu_out;
    logic        x_carry_out;
    logic        x_zero;
    logic        x_compare;
    logic [3:0]  x_out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    logic [22:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [23:0] prev_bundle;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .select(select), .mode(mode),
        .carry_in(carry_in), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .carry_out(carry_out),
        .zero(zero), .compare(compare), .out_tag(out_tag)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(x_rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_a(x_in_a), .in_b(x_in_b), .select(x_select), .mode(x_mode),
        .carry_in(x_carry_in), .in_tag(x_in_tag), .out_valid(x_out_valid),
        .out_ready(x_out_ready), .alu_out(x_alu_out), .carry_out(x_carry_out),
        .zero(x_zero), .compare(x_compare), .out_tag(x_out_tag)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: logic mode as a per-bit truth table indexed by (a,b);
    // arithmetic mode as plain integer addition of the (X,Y) operand pair.
    function automatic logic [17:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] sel, input logic md,
                                            input logic cin);
        logic [15:0] r;
        logic [15:0] nb;
        logic        c;
        int unsigned x, y, s, ua, ub, unb, ones;
        r = '0;
        c = 1'b0;
        nb = ~b;
        ua = a; ub = b; unb = nb; ones = 32'h0000_FFFF;
        if (md) begin
            for (int i = 0; i < 16; i++)
                r[i] = a[i] ? (b[i] ? sel[3] : sel[2]) : (b[i] ? ~sel[0] : ~sel[1]);
        end else begin
            case (sel)
                4'd0:  begin x = ua;        y = 0;          end
                4'd1:  begin x = ua | ub;   y = 0;          end
                4'd2:  begin x = ua | unb;  y = 0;          end
                4'd3:  begin x = 0;         y = ones;       end
                4'd4:  begin x = ua;        y = ua & unb;   end
                4'd5:  begin x = ua | ub;   y = ua & unb;   end
                4'd6:  begin x = ua;        y = unb;        end
                4'd7:  begin x = ua & unb;  y = ones;       end
                4'd8:  begin x = ua;        y = ua & ub;    end
                4'd9:  begin x = ua;        y = ub;         end
                4'd10: begin x = ua | unb;  y = ua & ub;    end
                4'd11: begin x = ua & ub;   y = ones;       end
                4'd12: begin x = ua;        y = ua;         end
                4'd13: begin x = ua | ub;   y = ua;         end
                4'd14: begin x = ua | unb;  y = ua;         end
                default: begin x = ua;      y = ones;       end
            endcase
            s = x + y + cin;
            r = s[15:0];
            c = s[16];
        end
        return {(r == 16'h0), c, r};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_val("hold", {out_valid, out_tag, compare, zero, carry_out, alu_out}, prev_bundle);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0)
                    check_val("spurious_out", out_valid, 1'b0);
                else
                    check_val("result", {out_tag, compare, zero, carry_out, alu_out}, exp_q.pop_front());
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, (in_a == in_b), ref_alu(in_a, in_b, select, mode, carry_in)});
            prev_stall  = out_valid && !out_ready;
            prev_bundle = {out_valid, out_tag, compare, zero, carry_out, alu_out};
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                          input logic md, input logic cin, input logic [3:0] tg);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_a = a; in_b = b; select = sel; mode = md; carry_in = cin; in_tag = tg;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check_val("send_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic op16(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sel, input logic md, input logic cin,
                        input logic [3:0] tg, input logic [15:0] e_res, input logic e_c,
                        input logic e_z, input logic e_cmp);
        send16(a, b, sel, md, cin, tg);
        @(negedge clk);
        check_val({name, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_val({name, "_valid"}, out_valid, 1'b1);
        check_val(name, {out_tag, compare, zero, carry_out, alu_out}, {tg, e_cmp, e_z, e_c, e_res});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 16'h1234; in_b = 16'h1234; select = 4'd9; mode = 1'b0; carry_in = 1'b1; in_tag = 4'd7;
        x_rst_n = 1'b0; x_in_valid = 1'b1; x_out_ready = 1'b1;
        x_in_a = 8'h11; x_in_b = 8'h22; x_select = 4'd9; x_mode = 1'b0; x_carry_in = 1'b0; x_in_tag = 4'd1;

        // Reset with in_valid held high
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_during", {out_valid, out_tag, compare, zero, carry_out, alu_out}, 24'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; x_rst_n = 1'b1; x_in_valid = 1'b0;
        @(negedge clk);
        check_val("rst_outputs", {out_valid, out_tag, compare, zero, carry_out, alu_out}, 24'h0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst8_outputs", {x_out_valid, x_out_tag, x_compare, x_zero, x_carry_out, x_alu_out}, 16'h0);
        check_val("rst8_in_ready", x_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed operations
        op16("add_wrap",  16'hFFFF, 16'h0001, 4'd9,  1'b0, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b1, 1'b0);
        op16("sub_cin1",  16'h0005, 16'h0003, 4'd6,  1'b0, 1'b1, 4'd4, 16'h0002, 1'b1, 1'b0, 1'b0);
        op16("sub_cin0",  16'h0005, 16'h0003, 4'd6,  1'b0, 1'b0, 4'd5, 16'h0001, 1'b1, 1'b0, 1'b0);
        op16("logic_xor", 16'hAAAA, 16'h5555, 4'd6,  1'b1, 1'b1, 4'd6, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        op16("logic_a",   16'h1234, 16'h1234, 4'd15, 1'b1, 1'b0, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b1);
        op16("logic_zero",16'hBEEF, 16'h0F0F, 4'd3,  1'b1, 1'b1, 4'd8, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: four back-to-back inputs, output stalled for cycles 2..5
        base = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send16(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'(i));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_val("bp_stall_out", {out_valid, out_tag}, {1'b1, 4'd0});
                    check_val("bp_in_ready", in_ready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check_val("bp_count", n_out - base, 4);
        check_val("bp_drain", exp_q.size(), 0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = 16'($urandom);
            in_b      = ($urandom_range(7) == 0) ? in_a : 16'($urandom);
            select    = 4'($urandom);
            mode      = 1'($urandom);
            carry_in  = 1'($urandom);
            in_tag    = 4'(c);
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_val("rand_drain", exp_q.size(), 0);

        // 8-bit instance: A + A + cin with wrap
        x_in_a = 8'h80; x_in_b = 8'h7F; x_select = 4'd12; x_mode = 1'b0; x_carry_in = 1'b1; x_in_tag = 4'd5;
        x_in_valid = 1'b1;
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
        @(negedge clk);
        check_val("w8_lat1", x_out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_val("w8_valid", x_out_valid, 1'b1);
        check_val("w8_result", {x_out_tag, x_compare, x_zero, x_carry_out, x_alu_out}, {4'd5, 1'b0, 1'b0, 1'b1, 8'h01});
        @(posedge clk);
        #1;

        // 8-bit instance: reset one cycle after an accepted input discards it
        x_in_a = 8'h12; x_in_b = 8'h34; x_select = 4'd9; x_mode = 1'b0; x_carry_in = 1'b0; x_in_tag = 4'd9;
        x_in_valid = 1'b1;
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
        x_rst_n = 1'b0;
        @(posedge clk);
        #1;
        x_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("w8_rst_discard", x_out_valid, 1'b0);
        end
        check_val("w8_rst_outputs", {x_out_tag, x_compare, x_zero, x_carry_out, x_alu_out}, 15'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
